ibuf_feeder: RTL and testbench

IBUF_FEEDER -- requirements
Module: ibuf_feeder

---
 rtl/ibuf_feeder_pkg.sv | 15 +
 rtl/ibuf_feeder_skew.sv | 61 ++++++
 rtl/ibuf_feeder.sv | 139 +++++++++++++
 tb/tb_ibuf_feeder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_feeder_pkg.sv
// Shared types and default sizes for the systolic input-buffer feeder.
package ibuf_feeder_pkg;

  localparam int DEFAULT_ARRAY_SIZE = 4;
  localparam int DEFAULT_DATA_W     = 32;
  localparam int ZERO_CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ibuf_feeder_skew.sv
// Per-row delay line: holds a valid/data pair for DEPTH cycles so that
// row r of the systolic array receives its element r cycles after row 0.
// The whole line freezes while stall is high.
module skew_delay
  import ibuf_feeder_pkg::*;
#(
  parameter int DEPTH  = 0,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              pending
);

  if (DEPTH == 0) begin : g_pass
    // Row 0 has no skew, so the element passes straight through.
    logic unused_pass;
    assign unused_pass = &{1'b0, clk, RST, stall};
    assign out_valid   = in_valid;
    assign out_data    = in_data;
    assign pending     = 1'b0;
  end else begin : g_shift
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

    // Shift one stage per non-stalled cycle; hold everything on stall.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (!stall) begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end
    end

    // Stage registers; reset empties the line.
    always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
        valid_q <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign pending   = |valid_q;
  end

endmodule

// File: rtl/ibuf_feeder.sv
// Reads a tile of column vectors from activation memory and writes them,
// skewed by one cycle per row, into the per-row input buffers of a
// systolic array. Also counts the zero elements written in the tile.
module ibuf_feeder
  import ibuf_feeder_pkg::*;
#(
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 8
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [LEN_W-1:0]             tile_len,
  input  logic                         stall,
  output logic                         mem_ren,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [ARRAY_SIZE*DATA_W-1:0] mem_rdata,
  output logic [ARRAY_SIZE-1:0]        ibuf_wr_en,
  output logic [ARRAY_SIZE*DATA_W-1:0] ibuf_data,
  output logic                         busy,
  output logic                         done,
  output logic [ZERO_CNT_W-1:0]        zero_cnt
);

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             base_q, base_d;
  logic [LEN_W-1:0]              len_q, len_d;
  logic [LEN_W-1:0]              k_q, k_d;
  logic                          rvalid_q, rvalid_d;
  logic [ARRAY_SIZE-1:0]         wr_en_q, wr_en_d;
  logic [ARRAY_SIZE*DATA_W-1:0]  data_q, data_d;
  logic [ZERO_CNT_W-1:0]         zero_cnt_q, zero_cnt_d;
  logic [ZERO_CNT_W:0]           zero_sum;
  logic [ARRAY_SIZE-1:0]         skew_valid;
  logic [ARRAY_SIZE-1:0]         skew_pending;
  logic [ARRAY_SIZE-1:0][DATA_W-1:0] skew_data;

  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
    skew_delay #(
      .DEPTH  (r),
      .DATA_W (DATA_W)
    ) u_skew (
      .clk       (clk),
      .RST       (RST),
      .stall     (stall),
      .in_valid  (rvalid_q),
      .in_data   (mem_rdata[r*DATA_W +: DATA_W]),
      .out_valid (skew_valid[r]),
      .out_data  (skew_data[r]),
      .pending   (skew_pending[r])
    );
  end

  assign mem_ren    = (state_q == FETCH) && !stall;
  assign mem_addr   = (state_q == FETCH) ? base_q + ADDR_W'(k_q) : '0;
  assign ibuf_wr_en = wr_en_q;
  assign ibuf_data  = data_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign zero_cnt   = zero_cnt_q;

  // Next-state: tile sequencing, read tracking, output staging, zero count.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    k_d        = k_q;
    wr_en_d    = wr_en_q;
    data_d     = data_q;
    zero_cnt_d = zero_cnt_q;
    zero_sum   = {1'b0, zero_cnt_q};
    rvalid_d   = stall ? rvalid_q : mem_ren;

    if (!stall) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        wr_en_d[r] = skew_valid[r];
        data_d[r*DATA_W +: DATA_W] = skew_valid[r] ? skew_data[r] : '0;
        if (skew_valid[r] && (skew_data[r] == '0)) begin
          zero_sum = zero_sum + (ZERO_CNT_W+1)'(1);
        end
      end
      zero_cnt_d = zero_sum[ZERO_CNT_W] ? '1 : zero_sum[ZERO_CNT_W-1:0];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_addr;
          len_d      = tile_len;
          k_d        = '0;
          zero_cnt_d = '0;
          state_d    = (tile_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (!stall) begin
          k_d = k_q + LEN_W'(1);
          if (k_q == len_q - LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!stall && !rvalid_q && !(|skew_pending)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any tile in flight.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      k_q        <= '0;
      rvalid_q   <= 1'b0;
      wr_en_q    <= '0;
      data_q     <= '0;
      zero_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      k_q        <= k_d;
      rvalid_q   <= rvalid_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

endmodule

// File: tb/tb_ibuf_feeder.sv
// Scoreboard bench for ibuf_feeder: tiles are loaded into a memory model,
// the expected per-row writes, read addresses and completion are queued,
// and a monitor process pops and compares whenever the DUT acts.
module tb_ibuf_feeder;

  localparam int N         = 4;
  localparam int DW        = 32;
  localparam int AW        = 10;
  localparam int LW        = 8;
  localparam int MEM_DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] tile_len = '0;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [N*DW-1:0] mem_rdata;
  logic [N-1:0]  ibuf_wr_en;
  logic [N*DW-1:0] ibuf_data;
  logic          busy;
  logic          done;
  logic [15:0]   zero_cnt;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    int len;
    int zeros;
  } tile_t;

  exp_t  rowQ [N][$];
  tile_t tileQ [$];
  int    addrQ [$];
  logic [N*DW-1:0] mem [MEM_DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCnt = 0;
  int activeCnt = 0;
  int t0 = 0;

  ibuf_feeder #(
    .ARRAY_SIZE (N),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .LEN_W      (LW)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .start      (start),
    .base_addr  (base_addr),
    .tile_len   (tile_len),
    .stall      (stall),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .ibuf_wr_en (ibuf_wr_en),
    .ibuf_data  (ibuf_data),
    .busy       (busy),
    .done       (done),
    .zero_cnt   (zero_cnt)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Activation memory: one-cycle read latency, output held between reads.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [N*DW-1:0] actual,
                             input logic [N*DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got an event, expected none", name);
  endtask

  task automatic flushScoreboard();
    for (int r = 0; r < N; r++) rowQ[r].delete();
    tileQ.delete();
    addrQ.delete();
  endtask

  // Reference model: element k of row r is accepted on the (3+k+r)-th
  // non-stalled cycle after the start cycle; reads walk base..base+len-1.
  task automatic loadTile(input int base, input int len, input int dataMode);
    logic [N*DW-1:0] vec;
    logic [DW-1:0]   val;
    exp_t            e;
    tile_t           t;
    int              zeros;
    int              idx;
    zeros = 0;
    for (int k = 0; k < len; k++) begin
      idx = (base + k) % MEM_DEPTH;
      vec = '0;
      for (int r = 0; r < N; r++) begin
        case (dataMode)
          0:       val = DW'((k + 1) * r + 1);
          1:       val = (r == 1 || r == 3) ? '0 : DW'(k * 16 + r + 7);
          default: val = ($urandom_range(3) == 0) ? '0 : DW'($urandom);
        endcase
        vec[r*DW +: DW] = val;
        if (val == '0) zeros++;
        e.data = val;
        e.due  = 3 + k + r;
        rowQ[r].push_back(e);
      end
      mem[idx] = vec;
      addrQ.push_back(idx);
    end
    t.len   = len;
    t.zeros = zeros;
    tileQ.push_back(t);
  endtask

  // stallMode: 0 none, 1 window [stallLo,stallHi], 2 random.
  task automatic applyStimulus(input int base, input int len, input int dataMode,
                               input int stallMode, input int stallLo,
                               input int stallHi, input int busyStartAt);
    int rel;
    int doneBefore;
    int left;
    loadTile(base, len, dataMode);
    doneBefore = doneCnt;
    base_addr  = AW'(base);
    tile_len   = LW'(len);
    start      = 1'b1;
    stall      = (stallMode == 2) ? ($urandom_range(4) == 0) : 1'b0;
    rel = 0;
    do begin
      @(posedge clk);
      #1;
      rel++;
      start = (rel == busyStartAt);
      if (start) begin
        base_addr = AW'($urandom);
        tile_len  = LW'($urandom_range(1, 10));
      end
      case (stallMode)
        1:       stall = (rel >= stallLo && rel <= stallHi);
        2:       stall = ($urandom_range(4) == 0);
        default: stall = 1'b0;
      endcase
    end while (doneCnt == doneBefore && rel < 500);
    start = 1'b0;
    stall = 1'b0;
    if (doneCnt == doneBefore) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 500 cycles");
      flushScoreboard();
    end
    @(posedge clk);
    #1;
    left = 0;
    for (int r = 0; r < N; r++) left += rowQ[r].size();
    checkOutput("idle_after_done", busy, 1'b0);
    checkOutput("rows_drained", left, 0);
    checkOutput("reads_drained", addrQ.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_ren"}, mem_ren, 1'b0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_wr_en"}, ibuf_wr_en, 0);
    checkOutput({tag, "_data"}, ibuf_data, 0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_zero_cnt"}, zero_cnt, 0);
  endtask

  task automatic runResetAbort();
    int doneBefore;
    loadTile(64, 8, 2);
    base_addr = AW'(64);
    tile_len  = LW'(8);
    stall     = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    RST = 1'b1;
    flushScoreboard();
    #1;
    checkAllZero("abort");
    @(posedge clk);
    #1;
    RST = 1'b0;
    doneBefore = doneCnt;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_no_done", doneCnt, doneBefore);
    checkOutput("abort_idle", busy, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reads, writes or finishes.
  task automatic runMonitor();
    logic [N-1:0]    prevWr;
    logic [N*DW-1:0] prevData;
    bit              prevStall;
    bit              prevOk;
    exp_t            e;
    tile_t           t;
    prevWr = '0;
    prevData = '0;
    prevStall = 1'b0;
    prevOk = 1'b0;
    forever begin
      @(negedge clk);
      if (RST) begin
        prevOk = 1'b0;
        continue;
      end
      if (prevOk && prevStall && busy) begin
        checkOutput("hold_wr_en", ibuf_wr_en, prevWr);
        checkOutput("hold_data", ibuf_data, prevData);
      end
      if (stall) checkOutput("stall_mem_ren", mem_ren, 1'b0);
      if (start && !busy) begin
        activeCnt = 0;
        t0 = cyc;
      end else begin
        if (done) begin
          if (tileQ.size() == 0) begin
            reportUnexpected("unexpected_done");
          end else begin
            t = tileQ.pop_front();
            if (t.len == 0) checkOutput("done_cycle_len0", cyc - t0, 1);
            else checkOutput("done_active_cycles", activeCnt, t.len + N + 1);
            checkOutput("zero_cnt_at_done", zero_cnt, t.zeros);
          end
          doneCnt++;
        end
        if (!stall) activeCnt++;
        if (mem_ren) begin
          if (addrQ.size() == 0) reportUnexpected("unexpected_read");
          else checkOutput("mem_addr", mem_addr, addrQ.pop_front());
        end
        if (!stall) begin
          for (int r = 0; r < N; r++) begin
            if (ibuf_wr_en[r]) begin
              if (rowQ[r].size() == 0) begin
                reportUnexpected($sformatf("unexpected_write_row%0d", r));
              end else begin
                e = rowQ[r].pop_front();
                checkOutput($sformatf("row%0d_data", r), ibuf_data[r*DW +: DW], e.data);
                checkOutput($sformatf("row%0d_timing", r), activeCnt, e.due);
              end
            end
          end
        end
      end
      prevWr    = ibuf_wr_en;
      prevData  = ibuf_data;
      prevStall = stall;
      prevOk    = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
    fork
      runMonitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    RST = 1'b0;
    checkAllZero("reset");

    applyStimulus(16, 4, 0, 0, 0, 0, -1);
    applyStimulus(0, 0, 2, 0, 0, 0, -1);
    applyStimulus(32, 6, 2, 1, 5, 7, -1);
    applyStimulus(100, 3, 1, 0, 0, 0, -1);
    runResetAbort();
    applyStimulus(200, 5, 2, 0, 0, 0, -1);
    applyStimulus(MEM_DEPTH - 2, 4, 2, 0, 0, 0, 3);

    $display("[TB] starting randomized tiles");
    repeat (16) begin
      applyStimulus($urandom_range(MEM_DEPTH - 1), $urandom_range(0, 10), 2, 2, 0, 0,
                    ($urandom_range(1) == 0) ? 3 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
